// File: rtl/stream_mux_n.sv
// N-channel stream multiplexer: per-channel FIFOs, round-robin arbitration, optional packet lock.
// Define STREAM_MUX_N_OVF_COUNT_EN to build the saturating per-channel drop counters.
module stream_mux_n #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DW          = 9,
  parameter int unsigned FIFO_AW     = 4,
  parameter int unsigned PACKET_MODE = 0
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NCH-1:0]          s_tvalid,
  input  logic [NCH*DW-1:0]       s_tdata,
  input  logic [NCH-1:0]          s_tlast,
  output logic [NCH-1:0]          s_tready,
  input  logic [NCH-1:0]          s_arb_req_suppress,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DW-1:0]           m_tdata,
  output logic                    m_tlast,
  output logic [$clog2(NCH)-1:0]  m_tid,
  output logic [NCH-1:0]          ovf_sticky,
  output logic [NCH*16-1:0]       ovf_count
);

  localparam int unsigned IdW   = $clog2(NCH);
  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned PtrW  = FIFO_AW + 1;
  localparam int unsigned WordW = DW + 1;

  typedef logic [WordW-1:0] word_t;
  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  // FIFO storage and pointers
  word_t                     mem_q [NCH][Depth];
  word_t                     mem_d [NCH][Depth];
  logic [NCH-1:0][PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [NCH-1:0][PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [NCH-1:0]            fifo_empty, fifo_full;
  word_t                     head [NCH];
  logic [NCH-1:0]            push, pop, drop;
  logic [NCH-1:0]            sticky_q, sticky_d;

  // Arbitration and lock state
  logic [NCH-1:0]            eligible;
  logic                      rr_found;
  logic [IdW-1:0]            rr_grant;
  logic [IdW-1:0]            rr_idx;
  logic [IdW-1:0]            rr_ptr_q, rr_ptr_d;
  state_e                    state_q, state_d;
  logic [IdW-1:0]            lock_ch_q, lock_ch_d;
  logic                      sel_valid;
  logic [IdW-1:0]            sel_ch;
  logic                      load;

  // Output register
  logic                      m_tvalid_q, m_tvalid_d;
  logic [DW-1:0]             m_tdata_q, m_tdata_d;
  logic                      m_tlast_q, m_tlast_d;
  logic [IdW-1:0]            m_tid_q, m_tid_d;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      fifo_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      fifo_full[i]  = (wr_ptr_q[i][FIFO_AW] != rd_ptr_q[i][FIFO_AW]) &&
                      (wr_ptr_q[i][FIFO_AW-1:0] == rd_ptr_q[i][FIFO_AW-1:0]);
      head[i]       = mem_q[i][rd_ptr_q[i][FIFO_AW-1:0]];
      eligible[i]   = !fifo_empty[i] && !s_arb_req_suppress[i];
    end
  end

  assign s_tready = ~fifo_full;

  // Round-robin search starting at rr_ptr_q
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      rr_idx = IdW'((32'(rr_ptr_q) + k) % NCH);
      if (!rr_found && eligible[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = rr_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_ch_d  = lock_ch_q;
    rr_ptr_d   = rr_ptr_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tid_d    = m_tid_q;
    pop        = '0;
    sel_valid  = rr_found;
    sel_ch     = rr_grant;

    // A locked channel is served regardless of suppress; an empty one stalls the output
    if (PACKET_MODE != 0 && state_q == StLocked) begin
      sel_valid = !fifo_empty[lock_ch_q];
      sel_ch    = lock_ch_q;
    end

    load = !m_tvalid_q || m_tready;

    if (load) begin
      m_tvalid_d = sel_valid;
      if (sel_valid) begin
        pop[sel_ch] = 1'b1;
        m_tdata_d   = head[sel_ch][DW-1:0];
        m_tlast_d   = head[sel_ch][DW];
        m_tid_d     = sel_ch;
        rr_ptr_d    = (sel_ch == IdW'(NCH - 1)) ? '0 : sel_ch + 1'b1;
        if (PACKET_MODE != 0) begin
          state_d   = head[sel_ch][DW] ? StIdle : StLocked;
          lock_ch_d = sel_ch;
        end
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sticky_d = sticky_q;
    push     = '0;
    drop     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      // A full FIFO still takes the write when its head is popped this cycle
      push[i] = s_tvalid[i] && (!fifo_full[i] || pop[i]);
      drop[i] = s_tvalid[i] && fifo_full[i] && !pop[i];
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i][FIFO_AW-1:0]] = {s_tlast[i], s_tdata[i*DW +: DW]};
        wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      end
      if (drop[i]) begin
        sticky_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sticky_q   <= '0;
      rr_ptr_q   <= '0;
      state_q    <= StIdle;
      lock_ch_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tid_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sticky_q   <= sticky_d;
      rr_ptr_q   <= rr_ptr_d;
      state_q    <= state_d;
      lock_ch_q  <= lock_ch_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      m_tid_q    <= m_tid_d;
    end
  end

  assign m_tvalid   = m_tvalid_q;
  assign m_tdata    = m_tdata_q;
  assign m_tlast    = m_tlast_q;
  assign m_tid      = m_tid_q;
  assign ovf_sticky = sticky_q;

`ifdef STREAM_MUX_N_OVF_COUNT_EN
  logic [NCH-1:0][15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (drop[i] && ovf_cnt_q[i] != 16'hFFFF) begin
        ovf_cnt_d[i] = ovf_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: one interleaving instance and one packet-mode instance
// share stimulus; each scenario checks the instance it targets.
module tb_stream_mux_n;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 9;
  localparam int unsigned AW  = 2;

`ifdef STREAM_MUX_N_OVF_COUNT_EN
  localparam logic [15:0] OvfExp = 16'd1;
`else
  localparam logic [15:0] OvfExp = 16'd0;
`endif

  logic              aclk = 1'b0;
  logic              areset;
  logic [NCH-1:0]    s_tvalid, s_tlast, s_arb_req_suppress;
  logic [NCH*DW-1:0] s_tdata;
  logic              m_tready;

  logic [NCH-1:0]    s_tready0, s_tready1, ovf_sticky0, ovf_sticky1;
  logic              m_tvalid0, m_tvalid1, m_tlast0, m_tlast1;
  logic [DW-1:0]     m_tdata0, m_tdata1;
  logic [1:0]        m_tid0, m_tid1;
  logic [NCH*16-1:0] ovf_count0, ovf_count1;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  stream_mux_n #(.NCH(NCH), .DW(DW), .FIFO_AW(AW), .PACKET_MODE(0)) u_dut0 (
    .aclk               (aclk),
    .areset             (areset),
    .s_tvalid           (s_tvalid),
    .s_tdata            (s_tdata),
    .s_tlast            (s_tlast),
    .s_tready           (s_tready0),
    .s_arb_req_suppress (s_arb_req_suppress),
    .m_tvalid           (m_tvalid0),
    .m_tready           (m_tready),
    .m_tdata            (m_tdata0),
    .m_tlast            (m_tlast0),
    .m_tid              (m_tid0),
    .ovf_sticky         (ovf_sticky0),
    .ovf_count          (ovf_count0)
  );

  stream_mux_n #(.NCH(NCH), .DW(DW), .FIFO_AW(AW), .PACKET_MODE(1)) u_dut1 (
    .aclk               (aclk),
    .areset             (areset),
    .s_tvalid           (s_tvalid),
    .s_tdata            (s_tdata),
    .s_tlast            (s_tlast),
    .s_tready           (s_tready1),
    .s_arb_req_suppress (s_arb_req_suppress),
    .m_tvalid           (m_tvalid1),
    .m_tready           (m_tready),
    .m_tdata            (m_tdata1),
    .m_tlast            (m_tlast1),
    .m_tid              (m_tid1),
    .ovf_sticky         (ovf_sticky1),
    .ovf_count          (ovf_count1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input int d, input string tag, input logic [1:0] tid,
                            input logic [DW-1:0] data, input logic last);
    if (d == 0) begin
      check({tag, ".valid"}, 64'(m_tvalid0), 64'd1);
      check({tag, ".tid"},   64'(m_tid0),    64'(tid));
      check({tag, ".data"},  64'(m_tdata0),  64'(data));
      check({tag, ".last"},  64'(m_tlast0),  64'(last));
    end else begin
      check({tag, ".valid"}, 64'(m_tvalid1), 64'd1);
      check({tag, ".tid"},   64'(m_tid1),    64'(tid));
      check({tag, ".data"},  64'(m_tdata1),  64'(data));
      check({tag, ".last"},  64'(m_tlast1),  64'(last));
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    s_tvalid           = '0;
    s_tlast            = '0;
    s_tdata            = '0;
    s_arb_req_suppress = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    areset = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  task automatic set_beat(input int ch, input logic [DW-1:0] d, input logic last);
    s_tvalid[ch]          = 1'b1;
    s_tdata[ch*DW +: DW]  = d;
    s_tlast[ch]           = last;
  endtask

  initial begin
    areset   = 1'b1;
    m_tready = 1'b0;
    idle_inputs();

    // Reset state
    do_reset();
    check("rst.valid0",  64'(m_tvalid0),   64'd0);
    check("rst.data0",   64'(m_tdata0),    64'd0);
    check("rst.last0",   64'(m_tlast0),    64'd0);
    check("rst.tid0",    64'(m_tid0),      64'd0);
    check("rst.ready0",  64'(s_tready0),   64'hF);
    check("rst.sticky0", 64'(ovf_sticky0), 64'd0);
    check("rst.count0",  ovf_count0,       64'd0);
    check("rst.valid1",  64'(m_tvalid1),   64'd0);
    check("rst.ready1",  64'(s_tready1),   64'hF);

    // All channels streaming, sink always ready: tid 0,1,2,3,0 back to back
    m_tready = 1'b1;
    for (int i = 0; i < NCH; i++) set_beat(i, DW'(9'h10 + i), 1'b1);
    tick();
    check("rr.lat", 64'(m_tvalid0), 64'd0);
    for (int n = 0; n < 5; n++) begin
      tick();
      check_beat(0, "rr", 2'(n % 4), DW'(9'h10 + (n % 4)), 1'b1);
    end

    // FIFO overflow: depth 4 plus output register, sixth beat dropped
    do_reset();
    m_tready = 1'b0;
    for (int b = 1; b <= 6; b++) begin
      set_beat(0, DW'(b), 1'b1);
      tick();
      if (b == 1) check("ovf.lat", 64'(m_tvalid0), 64'd0);
      if (b == 5) begin
        check("ovf.full_ready", 64'(s_tready0),   64'hE);
        check("ovf.no_sticky",  64'(ovf_sticky0), 64'd0);
      end
    end
    check("ovf.sticky", 64'(ovf_sticky0),      64'h1);
    check("ovf.count",  64'(ovf_count0[15:0]), 64'(OvfExp));
    check("ovf.count_other", 64'(ovf_count0[63:16]), 64'd0);
    check_beat(0, "ovf.held", 2'd0, 9'd1, 1'b1);
    s_tvalid = '0;
    m_tready = 1'b1;
    for (int b = 2; b <= 5; b++) begin
      tick();
      check_beat(0, "ovf.drain", 2'd0, DW'(b), 1'b1);
    end
    tick();
    check("ovf.empty",       64'(m_tvalid0),   64'd0);
    check("ovf.sticky_hold", 64'(ovf_sticky0), 64'h1);

    // Suppress excludes channel 0 until released
    do_reset();
    m_tready = 1'b1;
    s_arb_req_suppress = 4'b0001;
    set_beat(0, 9'h0A0, 1'b1);
    set_beat(3, 9'h0A3, 1'b1);
    tick();
    s_tvalid = '0;
    tick();
    check_beat(0, "sup.ch3", 2'd3, 9'h0A3, 1'b1);
    tick();
    check("sup.blocked", 64'(m_tvalid0), 64'd0);
    s_arb_req_suppress = '0;
    tick();
    check_beat(0, "sup.ch0", 2'd0, 9'h0A0, 1'b1);

    // Packet lock: channel 1 holds the grant through an empty gap and its own suppress
    do_reset();
    m_tready = 1'b1;
    set_beat(1, 9'h1A1, 1'b0);
    set_beat(2, 9'h0B2, 1'b1);
    tick();
    s_tvalid = '0;
    tick();
    check_beat(1, "pkt.b0", 2'd1, 9'h1A1, 1'b0);
    s_arb_req_suppress = 4'b0010;
    set_beat(1, 9'h1A2, 1'b0);
    tick();
    check("pkt.gap", 64'(m_tvalid1), 64'd0);
    check_beat(0, "nopkt.rearb", 2'd2, 9'h0B2, 1'b1);
    set_beat(1, 9'h1A3, 1'b1);
    tick();
    check_beat(1, "pkt.b1", 2'd1, 9'h1A2, 1'b0);
    s_tvalid = '0;
    tick();
    check_beat(1, "pkt.b2", 2'd1, 9'h1A3, 1'b1);
    tick();
    check_beat(1, "pkt.next", 2'd2, 9'h0B2, 1'b1);

    // Reset mid-packet discards the lock, FIFO contents and arbiter position
    do_reset();
    m_tready = 1'b1;
    set_beat(1, 9'h111, 1'b0);
    tick();
    set_beat(1, 9'h112, 1'b0);
    tick();
    check_beat(1, "mid.b0", 2'd1, 9'h111, 1'b0);
    s_tvalid = '0;
    areset   = 1'b1;
    tick();
    areset   = 1'b0;
    check("mid.valid", 64'(m_tvalid1), 64'd0);
    check("mid.ready", 64'(s_tready1), 64'hF);
    check("mid.last",  64'(m_tlast1),  64'd0);
    check("mid.tid",   64'(m_tid1),    64'd0);
    set_beat(0, 9'h120, 1'b1);
    set_beat(1, 9'h121, 1'b1);
    set_beat(3, 9'h123, 1'b1);
    tick();
    s_tvalid = '0;
    tick();
    check_beat(1, "mid.first", 2'd0, 9'h120, 1'b1);
    tick();
    check_beat(1, "mid.second", 2'd1, 9'h121, 1'b1);
    tick();
    check_beat(1, "mid.third", 2'd3, 9'h123, 1'b1);
    tick();
    check("mid.drained", 64'(m_tvalid1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
